// File: rtl/seg_display_pkg.sv
// seg_display_pkg: shared debounce state encoding and default display register address.
package seg_display_pkg;
  typedef enum logic [1:0] {
    LOW       = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } deb_state_e;
  localparam logic [31:0] C_MMIO_ADDR_DEFAULT = 32'hFFFF_FC60;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronises a raw push button and emits a one-cycle press on an accepted rising level.
module btn_debounce
  import seg_display_pkg::*;
#(
  parameter int C_DEBOUNCE_CYCLES = 10000
) (
  input  logic I_clk,
  input  logic I_rst_n,
  input  logic I_btn,
  output logic O_press
);
  localparam int W = $clog2(C_DEBOUNCE_CYCLES + 1);
  localparam logic [W-1:0] CNT_MAX = W'(C_DEBOUNCE_CYCLES - 1);
  logic [1:0]   sync_q;
  deb_state_e   state_q;
  logic [W-1:0] cnt_q;
  logic         btn_s;
  logic         done;
  assign btn_s = sync_q[1];
  assign done  = cnt_q == CNT_MAX;
  // Mealy press lets the page advance on the same edge the FSM enters HIGH.
  assign O_press = state_q == WAIT_HIGH && btn_s && done;
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      sync_q  <= '0;
      state_q <= LOW;
      cnt_q   <= '0;
    end else begin
      sync_q <= {sync_q[0], I_btn};
      case (state_q)
        LOW: if (btn_s) begin
          state_q <= WAIT_HIGH;
          cnt_q   <= '0;
        end
        WAIT_HIGH: begin
          if (!btn_s) state_q <= LOW;
          else if (done) state_q <= HIGH;
          else cnt_q <= cnt_q + 1'b1;
        end
        HIGH: if (!btn_s) begin
          state_q <= WAIT_LOW;
          cnt_q   <= '0;
        end
        WAIT_LOW: begin
          if (btn_s) state_q <= HIGH;
          else if (done) state_q <= LOW;
          else cnt_q <= cnt_q + 1'b1;
        end
      endcase
    end
  end
endmodule

// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl: MMIO display register with byte paging driven by a debounced button or auto-scroll.
module seg_display_ctrl
  import seg_display_pkg::*;
#(
  parameter logic [31:0] C_MMIO_ADDR       = C_MMIO_ADDR_DEFAULT,
  parameter int          C_DEBOUNCE_CYCLES = 10000,
  parameter int          C_SCROLL_CYCLES   = 50_000_000
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        I_we,
  input  logic [31:0] I_addr,
  input  logic [31:0] I_wdata,
  input  logic [3:0]  I_be,
  input  logic        I_btn_next,
  input  logic        I_sw_auto,
  output logic [7:0]  O_show_num,
  output logic [1:0]  O_page,
  output logic [31:0] O_rdata,
  output logic        O_hit
);
  localparam int SW = $clog2(C_SCROLL_CYCLES);
  localparam logic [SW-1:0] SCROLL_MAX = SW'(C_SCROLL_CYCLES - 1);
  logic [31:0]   value_q, value_d;
  logic [1:0]    page_q;
  logic [1:0]    auto_q;
  logic [SW-1:0] scroll_q;
  logic          press, tick, auto_s;
  logic          unused_addr;
  assign unused_addr = ^I_addr[1:0];
  assign O_hit  = I_addr[31:2] == C_MMIO_ADDR[31:2];
  assign auto_s = auto_q[1];
  assign tick   = auto_s && scroll_q == SCROLL_MAX;
  btn_debounce #(.C_DEBOUNCE_CYCLES(C_DEBOUNCE_CYCLES)) u_deb (
    .I_clk   (I_clk),
    .I_rst_n (I_rst_n),
    .I_btn   (I_btn_next),
    .O_press (press)
  );
  always_comb begin
    value_d = value_q;
    for (int i = 0; i < 4; i++)
      value_d[8*i +: 8] = (I_we && O_hit && I_be[i]) ? I_wdata[8*i +: 8] : value_q[8*i +: 8];
  end
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      value_q  <= '0;
      page_q   <= '0;
      auto_q   <= '0;
      scroll_q <= '0;
    end else begin
      value_q  <= value_d;
      page_q   <= page_q + {1'b0, press | tick};
      auto_q   <= {auto_q[0], I_sw_auto};
      // A press restarts the scroll period so the next tick is a full period away.
      scroll_q <= (!auto_s || press || tick) ? '0 : scroll_q + 1'b1;
    end
  end
  assign O_show_num = value_q[8*page_q +: 8];
  assign O_rdata    = value_q;
  assign O_page     = page_q;
endmodule

// File: tb/tb_seg_display_ctrl.sv
// tb_seg_display_ctrl: directed checks of writes, debounced paging, auto-scroll and reset.
module tb_seg_display_ctrl;
  localparam logic [31:0] ADDR = 32'hFFFF_FC60;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  be = '0;
  logic        btn = 1'b0;
  logic        sw_auto = 1'b0;
  logic [7:0]  show_num;
  logic [1:0]  page;
  logic [31:0] rdata;
  logic        hit;
  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  seg_display_ctrl #(
    .C_MMIO_ADDR       (ADDR),
    .C_DEBOUNCE_CYCLES (4),
    .C_SCROLL_CYCLES   (8)
  ) dut (
    .I_clk      (clk),
    .I_rst_n    (rst_n),
    .I_we       (we),
    .I_addr     (addr),
    .I_wdata    (wdata),
    .I_be       (be),
    .I_btn_next (btn),
    .I_sw_auto  (sw_auto),
    .O_show_num (show_num),
    .O_page     (page),
    .O_rdata    (rdata),
    .O_hit      (hit)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    we = 1'b1; addr = a; wdata = d; be = b;
    cyc(1);
    we = 1'b0; be = '0;
  endtask

  task automatic press_btn();
    btn = 1'b1;
    cyc(10);
    btn = 1'b0;
    cyc(10);
  endtask

  initial begin
    cyc(2);
    chk("rst_show", {24'd0, show_num}, 32'h0);
    chk("rst_page", {30'd0, page}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    addr = ADDR;      #1 chk("hit_base", {31'd0, hit}, 32'h1);
    addr = ADDR + 3;  #1 chk("hit_byte3", {31'd0, hit}, 32'h1);
    addr = ADDR + 4;  #1 chk("hit_next", {31'd0, hit}, 32'h0);
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    write(ADDR, 32'h12345678, 4'hF);
    chk("wr_rdata", rdata, 32'h12345678);
    chk("wr_show", {24'd0, show_num}, 32'h78);
    write(ADDR + 4, 32'hDEADBEEF, 4'hF);
    chk("wr_miss", rdata, 32'h12345678);
    write(ADDR, 32'hAABBCCDD, 4'b0100);
    chk("wr_lane2", rdata, 32'h12BB5678);
    chk("wr_lane2_show", {24'd0, show_num}, 32'h78);
    // hold button: page changes exactly 7 cycles after the rise
    btn = 1'b1;
    cyc(6);
    chk("press_early", {30'd0, page}, 32'h0);
    cyc(1);
    chk("press_page", {30'd0, page}, 32'h1);
    chk("press_show", {24'd0, show_num}, 32'h56);
    cyc(3);
    btn = 1'b0;
    cyc(10);
    chk("hold_once", {30'd0, page}, 32'h1);
    press_btn();
    chk("page2", {30'd0, page}, 32'h2);
    chk("page2_show", {24'd0, show_num}, 32'hBB);
    press_btn();
    chk("page3", {30'd0, page}, 32'h3);
    chk("page3_show", {24'd0, show_num}, 32'h12);
    press_btn();
    chk("page_wrap", {30'd0, page}, 32'h0);
    chk("page_wrap_show", {24'd0, show_num}, 32'h78);
    // bounce shorter than the debounce window
    btn = 1'b1;
    cyc(3);
    btn = 1'b0;
    cyc(10);
    chk("bounce", {30'd0, page}, 32'h0);
    // auto-scroll: first tick 10 edges after enabling, then every 8
    sw_auto = 1'b1;
    cyc(9);
    chk("tick1_early", {30'd0, page}, 32'h0);
    cyc(1);
    chk("tick1", {30'd0, page}, 32'h1);
    cyc(7);
    chk("tick2_early", {30'd0, page}, 32'h1);
    cyc(1);
    chk("tick2", {30'd0, page}, 32'h2);
    // press timed to coincide with the next tick
    cyc(1);
    btn = 1'b1;
    cyc(6);
    chk("coinc_early", {30'd0, page}, 32'h2);
    cyc(1);
    chk("coinc_single", {30'd0, page}, 32'h3);
    chk("coinc_show", {24'd0, show_num}, 32'h12);
    cyc(4);
    btn = 1'b0;
    cyc(3);
    chk("tick3_early", {30'd0, page}, 32'h3);
    cyc(1);
    chk("tick3", {30'd0, page}, 32'h0);
    sw_auto = 1'b0;
    cyc(12);
    chk("auto_off", {30'd0, page}, 32'h0);
    press_btn();
    press_btn();
    chk("pre_rst_page", {30'd0, page}, 32'h2);
    // reset while the debouncer is in WAIT_HIGH
    btn = 1'b1;
    cyc(4);
    rst_n = 1'b0;
    btn = 1'b0;
    #1;
    chk("mid_rst_page", {30'd0, page}, 32'h0);
    cyc(2);
    rst_n = 1'b1;
    cyc(12);
    chk("post_rst_page", {30'd0, page}, 32'h0);
    chk("post_rst_show", {24'd0, show_num}, 32'h0);
    chk("post_rst_rdata", rdata, 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
